// File: rtl/frogger_pkg.sv
// Shared constants, spawn FSM states and LFSR helper for the
// Frogger hazard lanes.
package frogger_pkg;

    localparam int LANE_W = 16;
    localparam int COL_W  = 4;
    localparam int LFSR_W = 8;
    localparam int GAP_W  = 4;
    localparam int LEN_W  = 3;

    // Taps b7, b5, b4, b3: x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic {
        SPACE = 1'b0,
        CAR   = 1'b1
    } spawn_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] v
    );
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_seed(
        input logic [LFSR_W-1:0] s
    );
        return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
    endfunction

endpackage

// File: rtl/car_spawner.sv
// LFSR-driven spawn FSM producing the entry cell for one lane.
// Guarantees full-length cars separated by a minimum gap.
module car_spawner
    import frogger_pkg::*;
#(
    parameter logic [7:0] SEED    = 8'hA5,
    parameter int         CAR_LEN = 2,
    parameter int         MIN_GAP = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic step,
    output logic e
);

    localparam logic [LFSR_W-1:0] SEED_INIT = lfsr_seed(SEED);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(MIN_GAP);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(CAR_LEN);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

    logic [LFSR_W-1:0] lfsr;
    spawn_state_t      state;
    spawn_state_t      state_n;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_n;
    logic [LEN_W-1:0]  len_cnt;
    logic [LEN_W-1:0]  len_n;
    logic [LEN_W-1:0]  len_inc;

    assign len_inc = len_cnt + LEN_ONE;

    always_comb begin
        e       = 1'b0;
        state_n = state;
        gap_n   = gap_cnt;
        len_n   = len_cnt;
        unique case (state)
            SPACE: begin
                if (gap_cnt >= GAP_MAX && lfsr[1:0] == 2'b00) begin
                    e     = 1'b1;
                    len_n = LEN_ONE;
                    // A one-cell car is complete as soon as it spawns
                    if (CAR_LEN > 1) begin
                        state_n = CAR;
                    end else begin
                        gap_n = '0;
                    end
                end else if (gap_cnt < GAP_MAX) begin
                    gap_n = gap_cnt + GAP_ONE;
                end
            end
            CAR: begin
                e     = 1'b1;
                len_n = len_inc;
                if (len_inc == LEN_MAX) begin
                    state_n = SPACE;
                    gap_n   = '0;
                end
            end
            default: begin
                state_n = SPACE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr    <= SEED_INIT;
            state   <= SPACE;
            gap_cnt <= '0;
            len_cnt <= '0;
        end else if (step) begin
            lfsr    <= lfsr_next(lfsr);
            state   <= state_n;
            gap_cnt <= gap_n;
            len_cnt <= len_n;
        end
    end

endmodule

// File: rtl/lane_hazard.sv
// One scrolling hazard lane: tick counter, lane shift register
// and registered frog/car overlap flag.
module lane_hazard
    import frogger_pkg::*;
#(
    parameter int         PERIOD  = 8,
    parameter bit         DIR     = 1'b0,
    parameter logic [7:0] SEED    = 8'hA5,
    parameter int         CAR_LEN = 2,
    parameter int         MIN_GAP = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              frog_in_lane,
    input  logic [COL_W-1:0]  frog_col,
    output logic [LANE_W-1:0] lane_pixels,
    output logic              hit
);

    localparam int               CNT_W    = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] tick;
    logic             step;
    logic             e;

    assign step = enable && (tick == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= '0;
        end else if (enable) begin
            tick <= step ? '0 : tick + CNT_ONE;
        end
    end

    car_spawner #(
        .SEED    (SEED),
        .CAR_LEN (CAR_LEN),
        .MIN_GAP (MIN_GAP)
    ) u_spawner (
        .clk   (clk),
        .reset (reset),
        .step  (step),
        .e     (e)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_pixels <= '0;
        end else if (step) begin
            if (DIR) begin
                lane_pixels <= {e, lane_pixels[LANE_W-1:1]};
            end else begin
                lane_pixels <= {lane_pixels[LANE_W-2:0], e};
            end
        end
    end

    // Overlap uses the pre-scroll lane, so hit trails a new pixel by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            hit <= 1'b0;
        end else begin
            hit <= frog_in_lane & lane_pixels[frog_col];
        end
    end

endmodule

// File: tb/tb_lane_hazard.sv
// Directed bench for lane_hazard: cadence, hit timing, edges,
// direction, freeze, mid-run reset and car spacing.
module tb_lane_hazard;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fil0, fil1, fil2;
    logic [3:0]  col0, col1, col2;
    logic [15:0] lane0, lane1, lane2;
    logic        hit0, hit1, hit2;

    int total = 0;
    int bad   = 0;

    logic [15:0] tbl [0:18];

    always #5 clk = ~clk;

    lane_hazard #(
        .PERIOD(4), .DIR(1'b0), .SEED(8'hA5), .CAR_LEN(2), .MIN_GAP(3)
    ) u0 (
        .clk(clk), .reset(reset), .enable(enable),
        .frog_in_lane(fil0), .frog_col(col0),
        .lane_pixels(lane0), .hit(hit0)
    );

    lane_hazard #(
        .PERIOD(4), .DIR(1'b0), .SEED(8'h00), .CAR_LEN(1), .MIN_GAP(1)
    ) u1 (
        .clk(clk), .reset(reset), .enable(enable),
        .frog_in_lane(fil1), .frog_col(col1),
        .lane_pixels(lane1), .hit(hit1)
    );

    lane_hazard #(
        .PERIOD(4), .DIR(1'b1), .SEED(8'hA5), .CAR_LEN(2), .MIN_GAP(3)
    ) u2 (
        .clk(clk), .reset(reset), .enable(enable),
        .frog_in_lane(fil2), .frog_col(col2),
        .lane_pixels(lane2), .hit(hit2)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    // Counts spacing violations: interior cars must be exactly cl
    // long, no car longer than cl, interior gaps at least mg.
    function automatic int lane_bad(input logic [15:0] l,
                                    input int cl, input int mg);
        int nbad = 0;
        int i = 0;
        int j;
        int len;
        while (i < 16) begin
            j = i;
            while (j < 15 && l[j+1] == l[i]) j++;
            len = j - i + 1;
            if (l[i]) begin
                if (len > cl) nbad++;
                else if (i > 0 && j < 15 && len != cl) nbad++;
            end else if (i > 0 && j < 15 && len < mg) begin
                nbad++;
            end
            i = j + 1;
        end
        return nbad;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic        pf0, pf2;
        logic [3:0]  pc0, pc2;
        logic [15:0] pre, pre2;
        int          v0, v1, v2, seen1;

        // Entry bits for SEED A5: cars start on steps 5 and 17
        for (int n = 0; n < 5; n++) tbl[n] = 16'h0000;
        tbl[5] = 16'h0001;
        for (int n = 6; n <= 16; n++) tbl[n] = 16'h0003 << (n - 6);
        tbl[17] = 16'h1801;
        tbl[18] = 16'h3003;

        reset  = 1'b1;
        enable = 1'b0;
        fil0 = 1'b1; col0 = 4'd0;
        fil1 = 1'b0; col1 = 4'd0;
        fil2 = 1'b0; col2 = 4'd15;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_lane0", lane0, 16'h0000);
        check("rst_hit0", hit0, 1'b0);
        check("rst_lane2", lane2, 16'h0000);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            cyc();
            if (i == 0 || i == 9 || i == 19) begin
                check("hold_lane0", lane0, 16'h0000);
                check("hold_hit0", hit0, 1'b0);
                check("hold_lane1", lane1, 16'h0000);
            end
        end

        enable = 1'b1;
        fil0 = 1'b0;
        fil2 = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            pf0 = fil0; pc0 = col0;
            pf2 = fil2; pc2 = col2;
            pre  = tbl[(k-1)/4];
            pre2 = rev16(pre);
            cyc();
            check("lane0", lane0, tbl[k/4]);
            check("hit0", hit0, pf0 & pre[pc0]);
            check("lane2", lane2, rev16(tbl[k/4]));
            check("hit2", hit2, pf2 & pre2[pc2]);
            case (k)
                15: begin fil0 = 1'b1; col0 = 4'd0; end
                24: col0 = 4'd1;
                25: col0 = 4'd5;
                26: begin fil0 = 1'b0; col0 = 4'd1; end
                27: begin fil0 = 1'b1; col0 = 4'd2; end
                40: col0 = 4'd15;
                default: ;
            endcase
        end

        col0 = 4'd0;
        fil0 = 1'b1;
        cyc();
        check("pre_rst_lane0", lane0, 16'h3003);
        check("pre_rst_hit0", hit0, 1'b1);
        reset = 1'b1;
        cyc();
        check("mid_rst_lane0", lane0, 16'h0000);
        check("mid_rst_hit0", hit0, 1'b0);
        check("mid_rst_lane2", lane2, 16'h0000);
        reset = 1'b0;
        fil0 = 1'b0;

        for (int j = 1; j <= 26; j++) begin
            cyc();
            check("restart_lane0", lane0, tbl[j/4]);
            check("restart_hit0", hit0, 1'b0);
        end

        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("freeze_lane0", lane0, 16'h0003);
        end
        enable = 1'b1;
        for (int m = 1; m <= 8; m++) begin
            cyc();
            check("resume_lane0", lane0, tbl[(26+m)/4]);
        end

        fil0 = 1'b0;
        fil2 = 1'b0;
        v0 = 0; v1 = 0; v2 = 0; seen1 = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            v0 += lane_bad(lane0, 2, 3);
            v1 += lane_bad(lane1, 1, 1);
            v2 += lane_bad(lane2, 2, 3);
            if (lane1 != 16'h0000) seen1 = 1;
        end
        check("space0", v0, 0);
        check("space1", v1, 0);
        check("space2", v2, 0);
        check("busy1", seen1, 1);
        check("hit1_idle", hit1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
